// File: rtl/if_id_fetch_stage_if.sv
// PC address stream, hazard controls, instruction-memory preload port and
// IF/ID register outputs for the fetch stage.
interface if_id_fetch_stage_if;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        pc_ready;
    logic        stall;
    logic        flush;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        id_err;

    // PC / hazard unit / preload side
    modport master (
        output pc_addr, pc_valid, stall, flush, imem_we, imem_waddr, imem_wdata,
        input  pc_ready, id_instr, id_pc4, id_valid, id_err
    );

    // Fetch stage side
    modport slave (
        input  pc_addr, pc_valid, stall, flush, imem_we, imem_waddr, imem_wdata,
        output pc_ready, id_instr, id_pc4, id_valid, id_err
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage: accepts PC addresses, reads a synchronous
// instruction memory and loads the IF/ID register. Words that arrive while
// the hazard unit stalls are parked in a 2-entry FIFO so nothing is lost;
// flush squashes the FIFO, the in-flight read and the IF/ID contents.
module if_id_fetch_stage #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    if_id_fetch_stage_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        err;
    } entry_t;

    logic [31:0] mem [MEM_WORDS];

    // p1: read launched on the accept edge, data valid one cycle later
    logic        rd_vld_p1;
    logic [31:0] rd_data_p1;
    logic [31:0] rd_pc4_p1;
    logic        rd_err_p1;

    entry_t      buf0;
    entry_t      buf1;
    logic [1:0]  buf_count;

    entry_t      arr;
    logic        accept;
    logic        push;
    logic        pop;

    // Upper/lower preload address bits outside the word index are ignored.
    logic unused_waddr_bits;
    assign unused_waddr_bits = ^{bus.imem_waddr[31:AW+2], bus.imem_waddr[1:0]};

    // Two slots total are shared by the FIFO and the outstanding read, so a
    // new read is only launched when at least one slot is free.
    assign bus.pc_ready = !rst && !bus.flush &&
                          ((buf_count + {1'b0, rd_vld_p1}) <= 2'd1);
    assign accept = bus.pc_valid && bus.pc_ready;

    // Decide what the arriving read does: bypass into IF/ID, or queue.
    always_comb begin
        arr.instr = rd_err_p1 ? NOP_INSTR : rd_data_p1;
        arr.pc4   = rd_pc4_p1;
        arr.err   = rd_err_p1;
        push      = 1'b0;
        pop       = 1'b0;
        if (!bus.flush) begin
            if (bus.stall) begin
                push = rd_vld_p1;
            end else begin
                pop  = (buf_count != 2'd0);
                push = rd_vld_p1 && (buf_count != 2'd0);
            end
        end
    end

    // Preload port; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.imem_we)
            mem[bus.imem_waddr[AW+1:2]] <= bus.imem_wdata;
    end

    // Memory read and its side-band; old data wins on a same-word write.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_data_p1 <= mem[bus.pc_addr[AW+1:2]];
            rd_pc4_p1  <= bus.pc_addr + 32'd4;
            rd_err_p1  <= (bus.pc_addr[1:0] != 2'b00);
        end
    end

    // In-flight flag; flush already blocks accept through pc_ready.
    always_ff @(posedge clk) begin
        if (rst)
            rd_vld_p1 <= 1'b0;
        else
            rd_vld_p1 <= accept;
    end

    // FIFO occupancy.
    always_ff @(posedge clk) begin
        if (rst || bus.flush)
            buf_count <= 2'd0;
        else if (push && !pop)
            buf_count <= buf_count + 2'd1;
        else if (pop && !push)
            buf_count <= buf_count - 2'd1;
    end

    // FIFO storage as a two-deep shift register, head in buf0.
    always_ff @(posedge clk) begin
        if (push && pop) begin
            if (buf_count == 2'd2) begin
                buf0 <= buf1;
                buf1 <= arr;
            end else begin
                buf0 <= arr;
            end
        end else if (pop) begin
            buf0 <= buf1;
        end else if (push) begin
            if (buf_count == 2'd0)
                buf0 <= arr;
            else
                buf1 <= arr;
        end
    end

    // IF/ID register: flush > stall > pop / bypass / bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.id_instr <= NOP_INSTR;
            bus.id_pc4   <= 32'd0;
            bus.id_valid <= 1'b0;
            bus.id_err   <= 1'b0;
        end else if (bus.flush) begin
            bus.id_instr <= NOP_INSTR;
            bus.id_valid <= 1'b0;
            bus.id_err   <= 1'b0;
        end else if (!bus.stall) begin
            if (buf_count != 2'd0) begin
                bus.id_instr <= buf0.instr;
                bus.id_pc4   <= buf0.pc4;
                bus.id_err   <= buf0.err;
                bus.id_valid <= 1'b1;
            end else if (rd_vld_p1) begin
                bus.id_instr <= arr.instr;
                bus.id_pc4   <= arr.pc4;
                bus.id_err   <= arr.err;
                bus.id_valid <= 1'b1;
            end else begin
                bus.id_instr <= NOP_INSTR;
                bus.id_err   <= 1'b0;
                bus.id_valid <= 1'b0;
            end
        end
    end

    // A push into a full FIFO without a pop would drop a word.
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(push && !pop && buf_count == 2'd2));
    end
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: streaming, stall buffering, flush,
// stall+flush priority, misaligned / wrapped addresses, and mid-stream reset.
module tb_if_id_fetch_stage;
    localparam int MEM_WORDS = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    if_id_fetch_stage_if bus ();

    if_id_fetch_stage #(.MEM_WORDS(MEM_WORDS), .NOP_INSTR(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid);
        chk({tag, ".instr"}, bus.id_instr, instr);
        chk({tag, ".pc4"},   bus.id_pc4,   pc4);
        chk({tag, ".valid"}, {31'd0, bus.id_valid}, {31'd0, valid});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [31:0] a);
        bus.pc_valid = v;
        bus.pc_addr  = a;
    endtask

    initial begin
        bus.pc_addr    = 32'd0;
        bus.pc_valid   = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.imem_we    = 1'b0;
        bus.imem_waddr = 32'd0;
        bus.imem_wdata = 32'd0;

        // Reset, with preload of words 0..3 while reset is held
        tick;
        for (int i = 0; i < 4; i++) begin
            bus.imem_we    = 1'b1;
            bus.imem_waddr = 32'(i * 4);
            bus.imem_wdata = 32'(8'h11 * (i + 1));
            tick;
        end
        bus.imem_we = 1'b0;
        bus.pc_valid = 1'b1;
        chk_id("rst", 32'h0, 32'h0, 1'b0);
        chk("rst.err", {31'd0, bus.id_err}, 32'd0);
        chk("rst.ready", {31'd0, bus.pc_ready}, 32'd0);
        bus.pc_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rel.ready", {31'd0, bus.pc_ready}, 32'd1);

        // 1: streaming 0,4,8,12
        req(1'b1, 32'd0);  tick;
        chk_id("t1.pre", 32'h0, 32'h0, 1'b0);
        req(1'b1, 32'd4);  tick;
        chk_id("t1.w0", 32'h11, 32'd4, 1'b1);
        chk("t1.ready", {31'd0, bus.pc_ready}, 32'd1);
        req(1'b1, 32'd8);  tick;
        chk_id("t1.w1", 32'h22, 32'd8, 1'b1);
        req(1'b1, 32'd12); tick;
        chk_id("t1.w2", 32'h33, 32'd12, 1'b1);
        req(1'b0, 32'd0);  tick;
        chk_id("t1.w3", 32'h44, 32'd16, 1'b1);
        tick;
        chk("t1.bubble", {31'd0, bus.id_valid}, 32'd0);

        // 2: stall for 3 cycles from the 2nd output
        req(1'b1, 32'd0);  tick;
        req(1'b1, 32'd4);  tick;
        chk_id("t2.w0", 32'h11, 32'd4, 1'b1);
        req(1'b1, 32'd8);  bus.stall = 1'b1; tick;
        chk_id("t2.s1", 32'h11, 32'd4, 1'b1);
        chk("t2.ready1", {31'd0, bus.pc_ready}, 32'd0);
        req(1'b0, 32'd0);  tick;
        chk_id("t2.s2", 32'h11, 32'd4, 1'b1);
        chk("t2.ready2", {31'd0, bus.pc_ready}, 32'd0);
        tick;
        chk_id("t2.s3", 32'h11, 32'd4, 1'b1);
        bus.stall = 1'b0;  tick;
        chk_id("t2.w1", 32'h22, 32'd8, 1'b1);
        chk("t2.ready3", {31'd0, bus.pc_ready}, 32'd1);
        tick;
        chk_id("t2.w2", 32'h33, 32'd12, 1'b1);
        tick;
        chk("t2.bubble", {31'd0, bus.id_valid}, 32'd0);

        // 3: flush with two buffered entries
        req(1'b1, 32'd0);  tick;
        req(1'b1, 32'd4);  tick;
        req(1'b1, 32'd8);  bus.stall = 1'b1; tick;
        req(1'b0, 32'd0);  tick;
        chk_id("t3.full", 32'h11, 32'd4, 1'b1);
        bus.stall = 1'b0;  bus.flush = 1'b1; req(1'b1, 32'd12);
        #1;
        chk("t3.ready_fl", {31'd0, bus.pc_ready}, 32'd0);
        tick;
        chk_id("t3.fl", 32'h0, 32'd4, 1'b0);
        bus.flush = 1'b0;
        #1;
        chk("t3.ready", {31'd0, bus.pc_ready}, 32'd1);
        tick;
        req(1'b0, 32'd0);
        chk("t3.nostale", {31'd0, bus.id_valid}, 32'd0);
        tick;
        chk_id("t3.w3", 32'h44, 32'd16, 1'b1);
        tick;
        chk("t3.bubble", {31'd0, bus.id_valid}, 32'd0);

        // 4: stall and flush together -> flush wins
        req(1'b1, 32'd0);  tick;
        req(1'b1, 32'd4);  tick;
        chk_id("t4.w0", 32'h11, 32'd4, 1'b1);
        req(1'b0, 32'd0);  bus.stall = 1'b1; tick;
        bus.flush = 1'b1;  tick;
        chk_id("t4.fl", 32'h0, 32'd4, 1'b0);
        bus.flush = 1'b0;  bus.stall = 1'b0; tick;
        chk("t4.empty", {31'd0, bus.id_valid}, 32'd0);

        // 5: misaligned and wrapped addresses
        req(1'b1, 32'h6);  tick;
        req(1'b0, 32'd0);  tick;
        chk_id("t5.mis", 32'h0, 32'hA, 1'b1);
        chk("t5.err", {31'd0, bus.id_err}, 32'd1);
        req(1'b1, 32'(MEM_WORDS * 4)); tick;
        req(1'b0, 32'd0);  tick;
        chk_id("t5.wrap", 32'h11, 32'(MEM_WORDS * 4 + 4), 1'b1);
        chk("t5.err0", {31'd0, bus.id_err}, 32'd0);

        // 6: reset mid-stream with buffer full
        bus.stall = 1'b1;
        req(1'b1, 32'd4);  tick;
        req(1'b1, 32'd8);  tick;
        req(1'b0, 32'd0);  tick;
        chk("t6.ready_full", {31'd0, bus.pc_ready}, 32'd0);
        rst = 1'b1;        tick;
        chk_id("t6.rst", 32'h0, 32'h0, 1'b0);
        chk("t6.ready_rst", {31'd0, bus.pc_ready}, 32'd0);
        rst = 1'b0;        bus.stall = 1'b0;
        #1;
        chk("t6.ready_rel", {31'd0, bus.pc_ready}, 32'd1);
        tick;
        chk("t6.empty", {31'd0, bus.id_valid}, 32'd0);
        req(1'b1, 32'd0);  tick;
        req(1'b1, 32'd12); tick;
        chk_id("t6.w0", 32'h11, 32'd4, 1'b1);
        req(1'b0, 32'd0);  tick;
        chk_id("t6.w3", 32'h44, 32'd16, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
